divider_8by4_seq: RTL

//  Sequential unsigned restoring divider. It is the inverse datapath to the 4x4 -> 8-bit

---
 rtl/divider_8by4_seq_if.sv | 25 ++
 rtl/divider_8by4_seq.sv | 135 +++++++++++++
 2 files changed

// File: rtl/divider_8by4_seq_if.sv
// Handshake bundle for the sequential restoring divider.
// The master side issues operands and consumes results; the slave side is the divider.
interface divider_8by4_seq_if #(
    parameter int W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [2*W-1:0]   dividend;
    logic [W-1:0]     divisor;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   quotient;
    logic [W-1:0]     remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divider_8by4_seq.sv
// Sequential unsigned restoring divider: 2W-bit dividend / W-bit divisor,
// one quotient bit per clock, valid/ready handshake on input and output.
// Results are latched into dedicated output registers only when an operation
// finishes, so quotient/remainder stay steady while the next division runs.
module divider_8by4_seq #(
    parameter int W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    divider_8by4_seq_if.slave     bus
);
    localparam int CW = $clog2(2 * W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W:0]      pr_q, pr_d;       // partial remainder, one bit wider than divisor
    logic [2*W-1:0]  dvd_q, dvd_d;     // dividend shift register, MSB consumed first
    logic [W-1:0]    dvs_q, dvs_d;
    logic [2*W-1:0]  qw_q, qw_d;       // working quotient
    logic [2*W-1:0]  quot_q, quot_d;   // published quotient
    logic [W-1:0]    rem_q, rem_d;     // published remainder
    logic            dbz_q, dbz_d;

    logic [W:0]      pr_sh_s;
    logic            ge_s;
    logic [W:0]      pr_nx_s;

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pr_q    <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            qw_q    <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            qw_q    <= qw_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    // One restoring step: shift in the next dividend bit and trial-subtract.
    always_comb begin
        pr_sh_s = {pr_q[W-1:0], dvd_q[2*W-1]};
        ge_s    = (pr_sh_s >= {1'b0, dvs_q});
        if (ge_s) begin
            pr_nx_s = pr_sh_s - {1'b0, dvs_q};
        end else begin
            pr_nx_s = pr_sh_s;
        end
    end

    // Next-state and datapath update for IDLE/BUSY/DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        qw_d    = qw_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    dvd_d = bus.dividend;
                    dvs_d = bus.divisor;
                    pr_d  = '0;
                    qw_d  = '0;
                    cnt_d = CW'(2 * W - 1);
                    dbz_d = 1'b0;
                    if (bus.divisor == '0) begin
                        // Division by zero short-circuits straight to DONE.
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = bus.dividend[W-1:0];
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                pr_d  = pr_nx_s;
                dvd_d = {dvd_q[2*W-2:0], 1'b0};
                qw_d  = {qw_q[2*W-2:0], ge_s};
                if (cnt_q == '0) begin
                    // Last bit: publish the finished result on this edge.
                    state_d = DONE;
                    quot_d  = {qw_q[2*W-2:0], ge_s};
                    rem_d   = pr_nx_s[W-1:0];
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule
